// File: rtl/oven_pkg.sv
// Shared state codes and limit arithmetic for the timed oven controller.
package oven_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_LOW   = 3'd1;
    localparam logic [STATE_W-1:0] ST_SET   = 3'd2;
    localparam logic [STATE_W-1:0] ST_HIGH  = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;
    localparam logic [STATE_W-1:0] ST_FAULT = 3'd5;

    // Callers truncate the result to TEMP_W+1 bits, so upper limits never wrap.
    function automatic logic [31:0] band_limit(input logic [31:0] base,
                                               input logic [31:0] delta,
                                               input logic        below);
        band_limit = below ? (base - delta) : (base + delta);
    endfunction

endpackage

// File: rtl/oven_tick_timer.sv
// Prescaler dividing clk by TICK_DIV and a saturating elapsed-tick counter.
module oven_tick_timer #(
    parameter int unsigned TIME_W   = 4,
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              clear,
    output logic [TIME_W-1:0] elapsed
);

    localparam int PRESC_W = $clog2(TICK_DIV);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [TIME_W-1:0]  elapsed_q, elapsed_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        presc_d   = presc_q;
        elapsed_d = elapsed_q;
        if (clear) begin
            presc_d   = '0;
            elapsed_d = '0;
        end else if (run) begin
            if (presc_q == PRESC_W'(TICK_DIV - 1)) begin
                presc_d = '0;
                if (elapsed_q != '1) begin
                    elapsed_d = elapsed_q + TIME_W'(1);
                end
            end else begin
                presc_d = presc_q + PRESC_W'(1);
            end
        end
    end

    // NOTE: reset is synchronous, so it sits inside the clocked branch, not the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q   <= '0;
            elapsed_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments to avoid race-dependent ordering.
            presc_q   <= presc_d;
            elapsed_q <= elapsed_d;
        end
    end

    assign elapsed = elapsed_q;

endmodule

// File: rtl/oven_ctrl_timed.sv
// Hysteresis oven thermostat with bake timer and sticky DONE state.
// Define OVEN_OVERTEMP_TRIP_EN to add the over-temperature trip into FAULT.
module oven_ctrl_timed
    import oven_pkg::*;
#(
    parameter int unsigned TEMP_W   = 8,
    parameter int unsigned TIME_W   = 4,
    parameter int unsigned HYST     = 10,
    parameter int unsigned TICK_DIV = 50_000_000
`ifdef OVEN_OVERTEMP_TRIP_EN
   ,parameter int unsigned TRIP_MARGIN = 30,
    parameter int unsigned TRIP_CYCLES = 16
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [TEMP_W-1:0]  temp,
    input  logic [TEMP_W-1:0]  set_temp,
    input  logic [TIME_W-1:0]  set_time,
    output logic [TIME_W-1:0]  elapsed,
    output logic [STATE_W-1:0] state_o,
    output logic               heater,
    output logic               led_idle,
    output logic               led_run,
    output logic               led_high,
    output logic               led_set,
    output logic               led_low,
    output logic               done,
    output logic               fault
);

    localparam int LIM_W = TEMP_W + 1;
    localparam logic [LIM_W-1:0] TEMP_MAX = LIM_W'((2 ** TEMP_W) - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [LIM_W-1:0]   temp_x, set_x, upper, lower;
    logic               valid, start_ok, time_up, run, clear, trip;

    assign temp_x   = {1'b0, temp};
    assign set_x    = {1'b0, set_temp};
    assign upper    = LIM_W'(band_limit(32'(set_temp), 32'(HYST), 1'b0));
    assign lower    = LIM_W'(band_limit(32'(set_temp), 32'(HYST), 1'b1));
    assign valid    = (set_x >= LIM_W'(HYST)) && (upper <= TEMP_MAX);
    assign start_ok = start && valid && (set_time != '0);
    assign time_up  = (elapsed >= set_time);
    assign run      = (state_q == ST_LOW) || (state_q == ST_SET) || (state_q == ST_HIGH);
    // Only IDLE/DONE can enter LOW from outside a run, which is exactly a new bake.
    assign clear    = !run && (state_d == ST_LOW);

`ifdef OVEN_OVERTEMP_TRIP_EN
    localparam int CNT_W = $clog2(TRIP_CYCLES + 1);

    logic [CNT_W-1:0] trip_cnt_q, trip_cnt_d;
    logic [LIM_W-1:0] trip_lim;
    logic             hot;

    assign trip_lim = LIM_W'(band_limit(32'(set_temp), 32'(TRIP_MARGIN), 1'b0));
    assign hot      = run && (temp_x >= trip_lim);

    always_comb begin
        trip_cnt_d = '0;
        if (hot) begin
            trip_cnt_d = (trip_cnt_q == CNT_W'(TRIP_CYCLES)) ? trip_cnt_q
                                                             : trip_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trip_cnt_q <= '0;
        end else begin
            trip_cnt_q <= trip_cnt_d;
        end
    end

    // Trip on the edge where the count reaches TRIP_CYCLES, not one edge later.
    assign trip = (trip_cnt_d == CNT_W'(TRIP_CYCLES));
`else
    assign trip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!stop && start_ok) state_d = ST_LOW;
            end
            ST_LOW, ST_SET, ST_HIGH: begin
                if (stop)          state_d = ST_IDLE;
                else if (trip)     state_d = ST_FAULT;
                else if (!valid)   state_d = ST_IDLE;
                else if (time_up)  state_d = ST_DONE;
                else begin
                    case (state_q)
                        ST_LOW:  if (temp_x > lower) state_d = ST_SET;
                        ST_SET:  begin
                            if (temp_x >= upper)      state_d = ST_HIGH;
                            else if (temp_x <= lower) state_d = ST_LOW;
                        end
                        default: if (temp_x < upper) state_d = ST_SET;
                    endcase
                end
            end
            ST_DONE: begin
                if (stop)          state_d = ST_IDLE;
                else if (start_ok) state_d = ST_LOW;
            end
            ST_FAULT: begin
                if (stop) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        heater   = 1'b0;
        led_idle = 1'b0;
        led_run  = 1'b0;
        led_high = 1'b0;
        led_set  = 1'b0;
        led_low  = 1'b0;
        done     = 1'b0;
        fault    = 1'b0;
        state_o  = state_q;
        case (state_q)
            ST_IDLE: led_idle = 1'b1;
            ST_LOW: begin
                heater  = 1'b1;
                led_low = 1'b1;
                led_run = 1'b1;
            end
            ST_SET: begin
                led_set = 1'b1;
                led_run = 1'b1;
            end
            ST_HIGH: begin
                led_high = 1'b1;
                led_run  = 1'b1;
            end
            ST_DONE: done = 1'b1;
`ifdef OVEN_OVERTEMP_TRIP_EN
            ST_FAULT: fault = 1'b1;
`endif
            default: ;
        endcase
    end

    oven_tick_timer #(
        .TIME_W  (TIME_W),
        .TICK_DIV(TICK_DIV)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (run),
        .clear  (clear),
        .elapsed(elapsed)
    );

endmodule

// File: tb/tb_oven_ctrl_timed.sv
// Self-checking bench for oven_ctrl_timed: directed scenarios plus random traffic
// compared against a cycle-count based behavioural model.
module tb_oven_ctrl_timed;

    localparam int HYST        = 10;
    localparam int TICK_DIV    = 4;
    localparam int TRIP_MARGIN = 30;
    localparam int TRIP_CYCLES = 3;
`ifdef OVEN_OVERTEMP_TRIP_EN
    localparam bit TRIP_EN = 1'b1;
`else
    localparam bit TRIP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] temp = 8'd0;
    logic [7:0] set_temp = 8'd100;
    logic [3:0] set_time = 4'd0;
    logic [3:0] elapsed;
    logic [2:0] state_o;
    logic       heater, led_idle, led_run, led_high, led_set, led_low, done, fault;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: state name code, run cycles since last start, consecutive hot run cycles.
    int m_state = 0;
    int m_runc  = 0;
    int m_hot   = 0;

    oven_ctrl_timed #(
        .TEMP_W  (8),
        .TIME_W  (4),
        .HYST    (HYST),
        .TICK_DIV(TICK_DIV)
`ifdef OVEN_OVERTEMP_TRIP_EN
       ,.TRIP_MARGIN(TRIP_MARGIN),
        .TRIP_CYCLES(TRIP_CYCLES)
`endif
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .stop    (stop),
        .temp    (temp),
        .set_temp(set_temp),
        .set_time(set_time),
        .elapsed (elapsed),
        .state_o (state_o),
        .heater  (heater),
        .led_idle(led_idle),
        .led_run (led_run),
        .led_high(led_high),
        .led_set (led_set),
        .led_low (led_low),
        .done    (done),
        .fault   (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_elapsed();
        int e;
        e = m_runc / TICK_DIV;
        return (e > 15) ? 15 : e;
    endfunction

    task automatic model_step();
        int  st, t, nxt, new_hot;
        bit  v, ok, in_run, trp;
        if (!rst_n) begin
            m_state = 0;
            m_runc  = 0;
            m_hot   = 0;
            return;
        end
        st      = int'(set_temp);
        t       = int'(temp);
        v       = (st >= HYST) && (st <= 255 - HYST);
        ok      = start && v && (set_time != 4'd0);
        in_run  = (m_state >= 1) && (m_state <= 3);
        new_hot = (in_run && (t >= st + TRIP_MARGIN)) ? m_hot + 1 : 0;
        trp     = TRIP_EN && (new_hot >= TRIP_CYCLES);
        nxt     = m_state;
        case (m_state)
            0: if (!stop && ok) nxt = 1;
            1, 2, 3: begin
                if (stop)                             nxt = 0;
                else if (trp)                         nxt = 5;
                else if (!v)                          nxt = 0;
                else if (m_elapsed() >= int'(set_time)) nxt = 4;
                else if (m_state == 1) begin
                    if (t > st - HYST) nxt = 2;
                end else if (m_state == 2) begin
                    if (t >= st + HYST)      nxt = 3;
                    else if (t <= st - HYST) nxt = 1;
                end else begin
                    if (t < st + HYST) nxt = 2;
                end
            end
            4: begin
                if (stop)    nxt = 0;
                else if (ok) nxt = 1;
            end
            5: if (stop) nxt = 0;
            default: nxt = 0;
        endcase
        if (in_run) m_runc++;
        if (nxt == 1 && !in_run) m_runc = 0;
        m_hot   = new_hot;
        m_state = nxt;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".state"},    32'(state_o),  32'(m_state));
        check({tag, ".heater"},   32'(heater),   32'(m_state == 1));
        check({tag, ".led_low"},  32'(led_low),  32'(m_state == 1));
        check({tag, ".led_set"},  32'(led_set),  32'(m_state == 2));
        check({tag, ".led_high"}, 32'(led_high), 32'(m_state == 3));
        check({tag, ".led_run"},  32'(led_run),  32'(m_state >= 1 && m_state <= 3));
        check({tag, ".led_idle"}, 32'(led_idle), 32'(m_state == 0));
        check({tag, ".done"},     32'(done),     32'(m_state == 4));
        check({tag, ".fault"},    32'(fault),    32'(m_state == 5));
        check({tag, ".elapsed"},  32'(elapsed),  32'(m_elapsed()));
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    initial begin
        // Reset from power-up
        rst_n = 1'b0;
        step("rst0");
        step("rst1");
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_led_idle", 32'(led_idle), 32'd1);
        rst_n = 1'b1;

        // Hysteresis band walk
        set_temp = 8'd100; set_time = 4'd15; temp = 8'd50; start = 1'b1;
        step("band_start");
        check("band_low", 32'(state_o), 32'd1);
        check("band_low_heat", 32'(heater), 32'd1);
        start = 1'b0;
        temp = 8'd95;  step("band95");  check("band_set", 32'(state_o), 32'd2);
        check("band_set_heat", 32'(heater), 32'd0);
        temp = 8'd110; step("band110"); check("band_high", 32'(state_o), 32'd3);
        temp = 8'd105; step("band105"); check("band_set2", 32'(state_o), 32'd2);
        temp = 8'd90;  step("band90");  check("band_low2", 32'(state_o), 32'd1);

        // Reset mid-run
        rst_n = 1'b0;
        step("mrst0");
        step("mrst1");
        check("mrst_state", 32'(state_o), 32'd0);
        check("mrst_heater", 32'(heater), 32'd0);
        check("mrst_elapsed", 32'(elapsed), 32'd0);
        check("mrst_idle", 32'(led_idle), 32'd1);
        rst_n = 1'b1;

        // Timer: three ticks of four clocks, DONE on the following edge
        set_time = 4'd3; temp = 8'd50; start = 1'b1;
        step("tmr_start");
        start = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            step("tmr");
            if (k == 4)  check("tmr_e1", 32'(elapsed), 32'd1);
            if (k == 8)  check("tmr_e2", 32'(elapsed), 32'd2);
            if (k == 12) check("tmr_e3", 32'(elapsed), 32'd3);
            if (k == 12) check("tmr_not_done", 32'(state_o), 32'd1);
        end
        check("tmr_done", 32'(done), 32'd1);
        check("tmr_done_heat", 32'(heater), 32'd0);
        check("tmr_done_el", 32'(elapsed), 32'd3);
        step("done_hold");
        step("done_hold");
        check("done_hold_el", 32'(elapsed), 32'd3);

        // start in DONE restarts with elapsed cleared
        start = 1'b1;
        step("done_restart");
        check("restart_state", 32'(state_o), 32'd1);
        check("restart_el", 32'(elapsed), 32'd0);
        start = 1'b0;

        // start in SET ignored
        temp = 8'd95; step("to_set");
        start = 1'b1; step("start_in_set");
        check("start_in_set", 32'(state_o), 32'd2);
        start = 1'b0;

        // stop and start together in LOW
        temp = 8'd50; step("to_low");
        start = 1'b1; stop = 1'b1; step("stop_start");
        check("stop_start", 32'(state_o), 32'd0);
        start = 1'b0; stop = 1'b0;

        // Validity
        set_temp = 8'd5; start = 1'b1; step("inval_start");
        check("inval_start", 32'(state_o), 32'd0);
        set_temp = 8'd100; step("val_start");
        check("val_start", 32'(state_o), 32'd1);
        start = 1'b0;
        set_temp = 8'd246; step("inval_mid");
        check("inval_mid", 32'(state_o), 32'd0);
        set_temp = 8'd100;

        // Lowering set_time below elapsed mid-run
        set_time = 4'd15; start = 1'b1; step("lower_start");
        start = 1'b0;
        for (int k = 0; k < 9; k++) step("lower_run");
        set_time = 4'd1; step("lower_now");
        check("lower_done", 32'(state_o), 32'd4);
        stop = 1'b1; step("lower_stop");
        stop = 1'b0;

        // Over-temperature: three hot cycles
        set_time = 4'd15; temp = 8'd50; start = 1'b1; step("trip_start");
        start = 1'b0;
        temp = 8'd130;
        step("trip_hot");
        step("trip_hot");
        step("trip_hot");
`ifdef OVEN_OVERTEMP_TRIP_EN
        check("trip_state", 32'(state_o), 32'd5);
        check("trip_fault", 32'(fault), 32'd1);
        check("trip_heater", 32'(heater), 32'd0);
        start = 1'b1; step("fault_start");
        check("fault_sticky", 32'(state_o), 32'd5);
`else
        check("notrip_state", 32'(state_o), 32'd3);
        check("notrip_fault", 32'(fault), 32'd0);
        start = 1'b1; step("notrip_start");
        check("notrip_start", 32'(state_o), 32'd3);
`endif
        start = 1'b0;
        stop = 1'b1; step("fault_stop");
        check("fault_stop", 32'(state_o), 32'd0);
        stop = 1'b0;

        // Two hot cycles then one degree cooler: no trip
        temp = 8'd50; start = 1'b1; step("near_start");
        start = 1'b0;
        temp = 8'd130; step("near_hot"); step("near_hot");
        temp = 8'd129; step("near_cool"); step("near_cool"); step("near_cool");
        check("near_state", 32'(state_o), 32'd3);
        check("near_fault", 32'(fault), 32'd0);
        stop = 1'b1; step("near_stop");
        stop = 1'b0;

        // Random traffic against the model
        set_temp = 8'd100; set_time = 4'd6;
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 149) != 0);
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 39) == 0) set_temp = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 19) == 0) set_temp = 8'd100;
            if ($urandom_range(0, 24) == 0) set_time = 4'($urandom_range(0, 15));
            temp = 8'($urandom_range(60, 145));
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
